// File: rtl/pll_cken_pkg.sv
// Shared types and helpers for the pll_cken_gen clock-enable generator.
// Holds the FSM state type, the default accumulator width and a rate helper.
package pll_cken_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } pll_state_e;

    localparam int ACC_W_DEF = 16;

    // Increment giving f_out from f_ref at the default width, rounded to nearest.
    function automatic longint rate_to_inc(input longint f_ref_hz, input longint f_out_hz);
        longint scaled;
        scaled = f_out_hz <<< ACC_W_DEF;
        if (f_ref_hz > 64'sd0) begin
            rate_to_inc = (scaled + (f_ref_hz / 64'sd2)) / f_ref_hz;
        end else begin
            rate_to_inc = 64'sd0;
        end
    endfunction

endpackage

// File: rtl/pll_cken_acc.sv
// Single-channel fractional phase accumulator with reloadable phase and increment.
// The carry output is the unregistered overflow of this cycle's sum.
module pll_cken_acc
    import pll_cken_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] RST_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             carry,
    output logic             acc_msb
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_r;
    logic [ACC_W:0]   sum_s;

    assign sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
    assign carry   = sum_s[ACC_W];
    assign acc_msb = acc_r[ACC_W-1];

    // Phase/increment registers: reload on request, otherwise wrap modulo 2^ACC_W.
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
            inc_r <= RST_INC;
        end else if (load) begin
            acc_r <= load_phase;
            inc_r <= load_inc;
        end else begin
            acc_r <= sum_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/pll_cken_gen.sv
// NUM_CH clock-enable generator with a PLL-style lock/reconfigure handshake.
// Optional square-wave outputs are built when PLL_CKEN_OUTCLK_EN is defined.
module pll_cken_gen
    import pll_cken_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_INC = int'(rate_to_inc(64'sd50_000_000, 64'sd25_000_000)),
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] cken,
    output logic              locked
`ifdef PLL_CKEN_OUTCLK_EN
    ,
    output logic [NUM_CH-1:0] outclk
`endif
);

    localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    pll_state_e        state_r, next_state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              accept_s;
    logic              locked_next_s;
    logic [CH_W-1:0]   lat_ch_r;
    logic [ACC_W-1:0]  lat_inc_r;
    logic [ACC_W-1:0]  lat_phase_r;
    logic              locked_r;
    logic              cfg_ready_r;
    logic [NUM_CH-1:0] cken_r;
    logic [NUM_CH-1:0] carry_s;
    logic [NUM_CH-1:0] msb_s;
    logic [NUM_CH-1:0] load_s;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign load_s[c] = (state_r == APPLY) && (lat_ch_r == CH_W'(c));

        pll_cken_acc #(
            .ACC_W   (ACC_W),
            .RST_INC (ACC_W'(DEFAULT_INC))
        ) u_acc (
            .refclk     (refclk),
            .rst        (rst),
            .load       (load_s[c]),
            .load_inc   (lat_inc_r),
            .load_phase (lat_phase_r),
            .carry      (carry_s[c]),
            .acc_msb    (msb_s[c])
        );
    end

    // Next-state logic: settle countdown, config acceptance, one-cycle apply.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            SETTLE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = LOCKED;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            LOCKED: begin
                if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_L)) begin
                    accept_s     = 1'b1;
                    next_state_s = APPLY;
                end else begin
                    next_state_s = LOCKED;
                end
            end
            APPLY: begin
                cnt_next_s   = CNT_LOAD;
                next_state_s = SETTLE;
            end
            default: begin
                cnt_next_s   = CNT_LOAD;
                next_state_s = SETTLE;
            end
        endcase
        locked_next_s = (next_state_s == LOCKED);
    end

    // State, handshake outputs and gated enables; a carry on an accept edge is dropped.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r     <= SETTLE;
            cnt_r       <= CNT_LOAD;
            locked_r    <= 1'b0;
            cfg_ready_r <= 1'b0;
            cken_r      <= {NUM_CH{1'b0}};
            lat_ch_r    <= {CH_W{1'b0}};
            lat_inc_r   <= {ACC_W{1'b0}};
            lat_phase_r <= {ACC_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            locked_r    <= locked_next_s;
            cfg_ready_r <= locked_next_s;
            cken_r      <= carry_s & {NUM_CH{locked_next_s}};
            if (accept_s) begin
                lat_ch_r    <= cfg_ch;
                lat_inc_r   <= cfg_inc;
                lat_phase_r <= cfg_phase;
            end
        end
    end

    assign cken      = cken_r;
    assign locked    = locked_r;
    assign cfg_ready = cfg_ready_r;

`ifdef PLL_CKEN_OUTCLK_EN
    logic [NUM_CH-1:0] outclk_r;

    // Square-wave copy of each accumulator MSB, held low while unlocked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            outclk_r <= {NUM_CH{1'b0}};
        end else begin
            outclk_r <= msb_s & {NUM_CH{locked_next_s}};
        end
    end

    assign outclk = outclk_r;
`else
    logic unused_msb_s;
    assign unused_msb_s = ^msb_s;
`endif

endmodule

// File: tb/tb_pll_cken_gen.sv
// Directed scoreboard bench for pll_cken_gen (3 channels so an out-of-range
// channel select is representable); outclk is checked when PLL_CKEN_OUTCLK_EN is set.
module tb_pll_cken_gen;

    localparam int NCH = 3;
    localparam int AW  = 16;
    localparam int LC  = 16;
    localparam int DEF = 32768;

    logic          refclk    = 1'b0;
    logic          rst       = 1'b1;
    logic          cfg_we    = 1'b0;
    logic [1:0]    cfg_ch    = 2'd0;
    logic [AW-1:0] cfg_inc   = 16'd0;
    logic [AW-1:0] cfg_phase = 16'd0;
    logic          cfg_ready;
    logic [NCH-1:0] cken;
    logic          locked;
`ifdef PLL_CKEN_OUTCLK_EN
    logic [NCH-1:0] outclk;
`endif

    pll_cken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC),
        .DEFAULT_INC (DEF)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_ready (cfg_ready),
        .cken      (cken),
        .locked    (locked)
`ifdef PLL_CKEN_OUTCLK_EN
        ,
        .outclk    (outclk)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NCH-1:0] cken;
        logic           locked;
        logic           ready;
        logic [NCH-1:0] oclk;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    // Behavioural reference: integer accumulators and a lock countdown.
    int m_acc[NCH];
    int m_inc[NCH];
    int m_st  = 0;
    int m_cnt = LC - 1;
    int m_ch  = 0;
    int m_ninc = 0;
    int m_ph  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge(output exp_t e);
        int nst;
        int s;
        logic [NCH-1:0] cy;
        logic [NCH-1:0] msb;
        e = '0;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0;
                m_inc[c] = DEF;
            end
            m_st  = 0;
            m_cnt = LC - 1;
        end else begin
            nst = m_st;
            for (int c = 0; c < NCH; c++) begin
                s      = m_acc[c] + m_inc[c];
                cy[c]  = (s >= 65536);
                msb[c] = (m_acc[c] >= 32768);
                m_acc[c] = s % 65536;
            end
            case (m_st)
                0: begin
                    if (m_cnt == 0) nst = 1;
                    else m_cnt = m_cnt - 1;
                end
                1: begin
                    if (cfg_we && (int'(cfg_ch) < NCH)) begin
                        m_ch   = int'(cfg_ch);
                        m_ninc = int'(cfg_inc);
                        m_ph   = int'(cfg_phase);
                        nst    = 2;
                    end
                end
                default: begin
                    m_acc[m_ch] = m_ph;
                    m_inc[m_ch] = m_ninc;
                    m_cnt = LC - 1;
                    nst   = 0;
                end
            endcase
            m_st     = nst;
            e.locked = (nst == 1);
            e.ready  = e.locked;
            e.cken   = e.locked ? cy : '0;
            e.oclk   = e.locked ? msb : '0;
        end
    endtask

    // One refclk edge: predict, push, wait, pop, compare.
    task automatic step();
        exp_t e;
        exp_t got;
        model_edge(e);
        sb_q.push_back(e);
        @(posedge refclk);
        #1;
        edge_cnt = rst ? 0 : edge_cnt + 1;
        got      = sb_q.pop_front();
        last_exp = got;
        chk("cken", 32'(cken), 32'(got.cken));
        chk("locked", 32'(locked), 32'(got.locked));
        chk("cfg_ready", 32'(cfg_ready), 32'(got.ready));
`ifdef PLL_CKEN_OUTCLK_EN
        chk("outclk", 32'(outclk), 32'(got.oclk));
`endif
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [AW-1:0] inc, input logic [AW-1:0] ph);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 64) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        int p1;
        int pc;
        int ec;
        int adj;
        logic prev0;

        // 1: reset, release, lock on the 16th edge, 2-cycle enables
        rst = 1'b1;
        repeat (3) step();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_cken", 32'(cken), 32'd0);
        rst = 1'b0;
        for (int i = 1; i < LC; i++) begin
            step();
            chk("settle_locked", 32'(locked), 32'd0);
            chk("settle_cken", 32'(cken), 32'd0);
        end
        step();
        chk("lock_edge", 32'(locked), 32'd1);
        chk("lock_cken", 32'(cken), 32'd7);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ch_equal", 32'(cken[1]), 32'(cken[0]));
            chk("ch0_ref", 32'(cken[0]), 32'(edge_cnt % 2 == 0));
        end

        // 2: ch1 to quarter rate; ch0 keeps its phase
        write_cfg(2'd1, 16'd16384, 16'd0);
        chk("accept_drop", 32'(locked), 32'd0);
        wait_lock(n);
        chk("relock_len", 32'(n), 32'd17);
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            p0 += int'(cken[0]);
            p1 += int'(cken[1]);
            chk("ch0_phase", 32'(cken[0]), 32'(edge_cnt % 2 == 0));
        end
        chk("ch1_quarter", 32'(p1), 32'd4);
        chk("ch0_half", 32'(p0), 32'd8);

        // 3: ch0 at ~1/3 rate, no adjacent pulses
        write_cfg(2'd0, 16'd21845, 16'd0);
        wait_lock(n);
        chk("relock_third", 32'(n), 32'd17);
        pc = 0;
        ec = 0;
        adj = 0;
        prev0 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            pc += int'(cken[0]);
            ec += int'(last_exp.cken[0]);
            if (cken[0] && prev0) adj++;
            prev0 = cken[0];
        end
        chk("third_count", 32'(pc), 32'(ec));
        chk("third_rate", 32'(pc >= 999 && pc <= 1000), 32'd1);
        chk("third_adjacent", 32'(adj), 32'd0);

        // 4: writes during APPLY/SETTLE and to an absent channel are ignored
        cfg_we    = 1'b1;
        cfg_ch    = 2'd1;
        cfg_inc   = 16'd32768;
        cfg_phase = 16'd0;
        step();
        cfg_ch  = 2'd0;
        cfg_inc = 16'd5;
        wait_lock(n);
        cfg_we = 1'b0;
        chk("settle_we_ignored", 32'(n), 32'd17);
        write_cfg(2'd3, 16'd7, 16'd0);
        chk("bad_ch_locked", 32'(locked), 32'd1);
        pc = 0;
        ec = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            chk("bad_ch_stay", 32'(locked), 32'd1);
            pc += int'(cken[0]);
            ec += int'(last_exp.cken[0]);
        end
        chk("ch0_inc_kept", 32'(pc), 32'(ec));

        // 5: inc=0 silences ch1; reset mid-reconfig restores defaults
        write_cfg(2'd1, 16'd0, 16'd0);
        wait_lock(n);
        chk("relock_zero", 32'(n), 32'd17);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("zero_inc", 32'(cken[1]), 32'd0);
        end
        write_cfg(2'd0, 16'd32768, 16'd0);
        repeat (5) step();
        chk("mid_settle", 32'(locked), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i < LC; i++) begin
            step();
            chk("rst_settle", 32'(locked), 32'd0);
        end
        step();
        chk("rst_relock", 32'(locked), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("default_ch1", 32'(cken[1]), 32'(edge_cnt % 2 == 0));
            chk("default_ch0", 32'(cken[0]), 32'(edge_cnt % 2 == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
